// File: rtl/sdram_frame_sequencer.sv
// Ping-pong frame sequencer between the pixel FIFO and the SDRAM controller:
// writes the incoming frame into one bank while reading the previous one back in bursts.
module sdram_frame_sequencer #(
    parameter int FrameWidth   = 640,
    parameter int FrameHeight  = 480,
    parameter int AddressWidth = 24,
    parameter int BurstLen     = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    i_vsync,
    input  logic                    i_fifo_empty,
    output logic                    o_fifo_rd_en,
    input  logic                    i_sdram_busy,
    output logic                    o_enable,
    output logic                    o_rw,
    output logic [AddressWidth-1:0] o_addr,
    output logic                    o_frame_start,
    output logic [1:0]              o_error
);

    localparam int NPix = FrameWidth * FrameHeight;
    localparam int IdxW = $clog2(NPix + 1);
    localparam int PixW = AddressWidth - 2;
    localparam logic [IdxW-1:0] NIdx     = IdxW'(NPix);
    localparam logic [IdxW-1:0] BurstIdx = IdxW'(BurstLen);
    localparam logic [IdxW-1:0] OneIdx   = IdxW'(1);

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        ARB    = 3'd1,
        WR_CMD = 3'd2,
        RD_CMD = 3'd3,
        WAIT   = 3'd4
    } state_t;

    // Bank is {1'b0, buffer select}; pixel index is zero-extended into the row/col field.
    function automatic logic [AddressWidth-1:0] make_addr(input logic bank_sel,
                                                          input logic [IdxW-1:0] idx);
        make_addr = {1'b0, bank_sel, {(PixW-IdxW){1'b0}}, idx};
    endfunction

    state_t                  state_r, state_s;
    logic                    vsync_meta_r, vsync_sync_r, vsync_prev_r;
    logic                    vsync_edge_s;
    logic                    wbuf_r, wbuf_s;
    logic [IdxW-1:0]         wr_idx_r, wr_idx_s;
    logic [IdxW-1:0]         rd_idx_r, rd_idx_s, rd_idx_inc_s;
    logic                    rd_active_r, rd_active_s;
    logic                    swap_pend_r, swap_pend_s, swap_req_s;
    logic [1:0]              error_r, error_s;
    logic                    frame_start_r, frame_start_s;
    logic                    enable_r, enable_s;
    logic                    rw_r, rw_s;
    logic [AddressWidth-1:0] addr_r, addr_s;
    logic                    fifo_rd_en_s;

    assign vsync_edge_s = vsync_sync_r & ~vsync_prev_r;
    assign swap_req_s   = vsync_edge_s | swap_pend_r;
    assign rd_idx_inc_s = rd_idx_r + BurstIdx;

    // Two-flop synchroniser for VSYNC plus a delayed copy for edge detection.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vsync_meta_r <= 1'b0;
            vsync_sync_r <= 1'b0;
            vsync_prev_r <= 1'b0;
        end else begin
            vsync_meta_r <= i_vsync;
            vsync_sync_r <= vsync_meta_r;
            vsync_prev_r <= vsync_sync_r;
        end
    end

    // Next-state, counter, swap and command-output decode.
    always_comb begin
        state_s       = state_r;
        wbuf_s        = wbuf_r;
        wr_idx_s      = wr_idx_r;
        rd_idx_s      = rd_idx_r;
        rd_active_s   = rd_active_r;
        error_s       = error_r;
        frame_start_s = 1'b0;
        fifo_rd_en_s  = 1'b0;
        enable_s      = 1'b0;
        rw_s          = rw_r;
        addr_s        = addr_r;

        // An edge seen outside ARB is held until the next arbitration slot.
        if (vsync_edge_s && (state_r != ARB) && (state_r != SYNC)) begin
            swap_pend_s = 1'b1;
        end else begin
            swap_pend_s = swap_pend_r;
        end

        case (state_r)
            SYNC: begin
                if (vsync_edge_s) begin
                    wr_idx_s = '0;
                    wbuf_s   = 1'b0;
                    state_s  = ARB;
                end else begin
                    state_s  = SYNC;
                end
            end
            ARB: begin
                if (swap_req_s) begin
                    swap_pend_s = 1'b0;
                    wr_idx_s    = '0;
                    if (wr_idx_r < NIdx) begin
                        error_s[0] = 1'b1;
                    end else begin
                        if (rd_active_r) begin
                            error_s[1] = 1'b1;
                        end else begin
                            error_s[1] = error_r[1];
                        end
                        wbuf_s        = ~wbuf_r;
                        rd_idx_s      = '0;
                        rd_active_s   = 1'b1;
                        frame_start_s = 1'b1;
                    end
                end else if (!i_fifo_empty && (wr_idx_r < NIdx)) begin
                    state_s = WR_CMD;
                end else if (!i_fifo_empty) begin
                    fifo_rd_en_s = 1'b1;
                end else if (rd_active_r && (rd_idx_r < NIdx)) begin
                    state_s = RD_CMD;
                end else begin
                    state_s = ARB;
                end
            end
            WR_CMD: begin
                if (!i_sdram_busy) begin
                    fifo_rd_en_s = 1'b1;
                    wr_idx_s     = wr_idx_r + OneIdx;
                    state_s      = WAIT;
                end else begin
                    state_s      = WR_CMD;
                end
            end
            RD_CMD: begin
                if (!i_sdram_busy) begin
                    rd_idx_s = rd_idx_inc_s;
                    if (rd_idx_inc_s >= NIdx) begin
                        rd_active_s = 1'b0;
                    end else begin
                        rd_active_s = 1'b1;
                    end
                    state_s = WAIT;
                end else begin
                    state_s = RD_CMD;
                end
            end
            WAIT: begin
                state_s = ARB;
            end
            default: begin
                state_s = SYNC;
            end
        endcase

        // Command outputs are registered from the next state so they hold until accepted.
        if (state_s == WR_CMD) begin
            enable_s = 1'b1;
            rw_s     = 1'b0;
            addr_s   = make_addr(wbuf_s, wr_idx_s);
        end else if (state_s == RD_CMD) begin
            enable_s = 1'b1;
            rw_s     = 1'b1;
            addr_s   = make_addr(~wbuf_s, rd_idx_s);
        end else begin
            enable_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r       <= SYNC;
            wbuf_r        <= 1'b0;
            wr_idx_r      <= '0;
            rd_idx_r      <= '0;
            rd_active_r   <= 1'b0;
            swap_pend_r   <= 1'b0;
            error_r       <= 2'b00;
            frame_start_r <= 1'b0;
            enable_r      <= 1'b0;
            rw_r          <= 1'b0;
            addr_r        <= '0;
        end else begin
            state_r       <= state_s;
            wbuf_r        <= wbuf_s;
            wr_idx_r      <= wr_idx_s;
            rd_idx_r      <= rd_idx_s;
            rd_active_r   <= rd_active_s;
            swap_pend_r   <= swap_pend_s;
            error_r       <= error_s;
            frame_start_r <= frame_start_s;
            enable_r      <= enable_s;
            rw_r          <= rw_s;
            addr_r        <= addr_s;
        end
    end

    assign o_fifo_rd_en  = fifo_rd_en_s;
    assign o_enable      = enable_r;
    assign o_rw          = rw_r;
    assign o_addr        = addr_r;
    assign o_frame_start = frame_start_r;
    assign o_error       = error_r;

endmodule

// File: tb/tb_sdram_frame_sequencer.sv
// Directed bench for sdram_frame_sequencer with a 4x2 frame and 8-word bursts;
// a counter-based FIFO model and a command log feed the per-scenario checks.
module tb_sdram_frame_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        i_vsync;
    logic        i_fifo_empty;
    logic        o_fifo_rd_en;
    logic        i_sdram_busy;
    logic        o_enable;
    logic        o_rw;
    logic [23:0] o_addr;
    logic        o_frame_start;
    logic [1:0]  o_error;

    int pushed = 0;
    int pops = 0;
    int n_checks = 0;
    int n_fail = 0;
    int rd_en_cnt = 0;
    int discard_cnt = 0;
    int fs_cnt = 0;
    int empty_pop_cnt = 0;
    logic        log_rw[$];
    logic [23:0] log_addr[$];

    sdram_frame_sequencer #(
        .FrameWidth  (4),
        .FrameHeight (2),
        .AddressWidth(24),
        .BurstLen    (8)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .i_vsync      (i_vsync),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd_en (o_fifo_rd_en),
        .i_sdram_busy (i_sdram_busy),
        .o_enable     (o_enable),
        .o_rw         (o_rw),
        .o_addr       (o_addr),
        .o_frame_start(o_frame_start),
        .o_error      (o_error)
    );

    always #5 CLK = ~CLK;

    assign i_fifo_empty = (pushed == pops);

    always @(posedge CLK) begin
        if (o_fifo_rd_en) pops <= pops + 1;
    end

    // Command log: a command is accepted at the next rising edge when enable=1 and busy=0.
    always @(negedge CLK) begin
        if (RST) begin
            if (o_enable && !i_sdram_busy) begin
                log_rw.push_back(o_rw);
                log_addr.push_back(o_addr);
            end
            if (o_fifo_rd_en) rd_en_cnt++;
            if (o_fifo_rd_en && !o_enable) discard_cnt++;
            if (o_frame_start) fs_cnt++;
            if (o_fifo_rd_en && i_fifo_empty) empty_pop_cnt++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse_vsync();
        i_vsync = 1'b1;
        cycles(6);
        i_vsync = 1'b0;
        cycles(2);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        i_vsync = 1'b0;
        i_sdram_busy = 1'b0;
        cycles(3);
        n_checks++;
        if ({o_enable, o_rw, o_addr, o_fifo_rd_en, o_frame_start, o_error} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%0b rw=%0b addr=%h rd=%0b fs=%0b err=%b want all zero",
                     o_enable, o_rw, o_addr, o_fifo_rd_en, o_frame_start, o_error);
        end
        RST = 1'b1;
        cycles(2);
    endtask

    task automatic test_first_frame();
        int s, r, f;
        s = log_addr.size(); r = rd_en_cnt; f = fs_cnt;
        pushed += 8;
        cycles(10);
        n_checks++;
        if (log_addr.size() - s !== 0) begin
            n_fail++; $display("FAIL pre_vsync_cmds: got %0d want 0", log_addr.size() - s);
        end
        pulse_vsync();
        cycles(40);
        n_checks++;
        if (log_addr.size() - s !== 8) begin
            n_fail++; $display("FAIL first_frame_count: got %0d want 8", log_addr.size() - s);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (log_rw[s+i] !== 1'b0 || log_addr[s+i] !== 24'(i)) begin
                n_fail++;
                $display("FAIL first_frame_cmd%0d: got rw=%0b addr=%h want rw=0 addr=%h",
                         i, log_rw[s+i], log_addr[s+i], 24'(i));
            end
        end
        n_checks++;
        if (rd_en_cnt - r !== 8) begin
            n_fail++; $display("FAIL first_frame_rd_en: got %0d want 8", rd_en_cnt - r);
        end
        n_checks++;
        if (fs_cnt - f !== 0) begin
            n_fail++; $display("FAIL first_frame_fs: got %0d want 0", fs_cnt - f);
        end
    endtask

    task automatic test_swap_read();
        int s, f;
        s = log_addr.size(); f = fs_cnt;
        pulse_vsync();
        cycles(20);
        n_checks++;
        if (fs_cnt - f !== 1) begin
            n_fail++; $display("FAIL swap_fs: got %0d want 1", fs_cnt - f);
        end
        n_checks++;
        if (log_addr.size() - s !== 1 || log_rw[s] !== 1'b1 || log_addr[s] !== 24'h000000) begin
            n_fail++;
            $display("FAIL swap_read: got n=%0d rw=%0b addr=%h want n=1 rw=1 addr=000000",
                     log_addr.size() - s, log_rw[s], log_addr[s]);
        end
        n_checks++;
        if (o_error !== 2'b00) begin
            n_fail++; $display("FAIL swap_error: got %b want 00", o_error);
        end
    endtask

    task automatic test_discard();
        int s, r, d;
        s = log_addr.size(); r = rd_en_cnt; d = discard_cnt;
        pushed += 10;
        cycles(60);
        n_checks++;
        if (log_addr.size() - s !== 8) begin
            n_fail++; $display("FAIL discard_write_count: got %0d want 8", log_addr.size() - s);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (log_rw[s+i] !== 1'b0 || log_addr[s+i] !== 24'h400000 + 24'(i)) begin
                n_fail++;
                $display("FAIL bank1_write%0d: got rw=%0b addr=%h want rw=0 addr=%h",
                         i, log_rw[s+i], log_addr[s+i], 24'h400000 + 24'(i));
            end
        end
        n_checks++;
        if (rd_en_cnt - r !== 10 || discard_cnt - d !== 2) begin
            n_fail++;
            $display("FAIL discard_pops: got rd_en=%0d discards=%0d want 10 and 2",
                     rd_en_cnt - r, discard_cnt - d);
        end
        n_checks++;
        if (o_error !== 2'b00) begin
            n_fail++; $display("FAIL discard_error: got %b want 00", o_error);
        end
    endtask

    task automatic test_overrun();
        int s, f;
        s = log_addr.size(); f = fs_cnt;
        pulse_vsync();
        cycles(20);
        n_checks++;
        if (fs_cnt - f !== 1 || log_addr.size() - s !== 1 || log_rw[s] !== 1'b1 ||
            log_addr[s] !== 24'h400000) begin
            n_fail++;
            $display("FAIL bank1_read: got fs=%0d n=%0d rw=%0b addr=%h want 1 1 1 400000",
                     fs_cnt - f, log_addr.size() - s, log_rw[s], log_addr[s]);
        end
        s = log_addr.size();
        pushed += 5;
        cycles(30);
        n_checks++;
        if (log_addr.size() - s !== 5 || log_addr[s+4] !== 24'h000004) begin
            n_fail++;
            $display("FAIL partial_writes: got n=%0d last=%h want 5 000004",
                     log_addr.size() - s, log_addr[s+4]);
        end
        s = log_addr.size(); f = fs_cnt;
        pulse_vsync();
        cycles(15);
        n_checks++;
        if (o_error !== 2'b01) begin
            n_fail++; $display("FAIL overrun_error: got %b want 01", o_error);
        end
        n_checks++;
        if (fs_cnt - f !== 0 || log_addr.size() - s !== 0) begin
            n_fail++;
            $display("FAIL overrun_no_swap: got fs=%0d cmds=%0d want 0 0", fs_cnt - f, log_addr.size() - s);
        end
        pushed += 1;
        cycles(10);
        n_checks++;
        if (log_addr.size() - s !== 1 || log_rw[s] !== 1'b0 || log_addr[s] !== 24'h000000) begin
            n_fail++;
            $display("FAIL overrun_restart: got n=%0d rw=%0b addr=%h want 1 0 000000",
                     log_addr.size() - s, log_rw[s], log_addr[s]);
        end
    endtask

    task automatic test_busy_hold();
        int s;
        s = log_addr.size();
        i_sdram_busy = 1'b1;
        pushed += 1;
        for (int k = 0; k < 20 && !o_enable; k++) cycles(1);
        n_checks++;
        if (o_enable !== 1'b1) begin
            n_fail++; $display("FAIL busy_cmd_timeout: got en=%0b want 1", o_enable);
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (o_enable !== 1'b1 || o_rw !== 1'b0 || o_addr !== 24'h000001 || o_fifo_rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_hold%0d: got en=%0b rw=%0b addr=%h rd=%0b want 1 0 000001 0",
                         k, o_enable, o_rw, o_addr, o_fifo_rd_en);
            end
            cycles(1);
        end
        i_sdram_busy = 1'b0;
        #1;
        n_checks++;
        if (o_fifo_rd_en !== 1'b1 || o_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_accept: got rd=%0b en=%0b want 1 1", o_fifo_rd_en, o_enable);
        end
        cycles(1);
        n_checks++;
        if (o_enable !== 1'b0 || log_addr.size() - s !== 1 || log_addr[s] !== 24'h000001) begin
            n_fail++;
            $display("FAIL busy_after: got en=%0b n=%0d addr=%h want 0 1 000001",
                     o_enable, log_addr.size() - s, log_addr[s]);
        end
        s = log_addr.size();
        pushed += 6;
        cycles(30);
        n_checks++;
        if (log_addr.size() - s !== 6 || log_addr[s+5] !== 24'h000007) begin
            n_fail++;
            $display("FAIL frame_fill: got n=%0d last=%h want 6 000007", log_addr.size() - s, log_addr[s+5]);
        end
    endtask

    task automatic test_write_priority();
        int s, f;
        logic found;
        s = log_addr.size(); f = fs_cnt; found = 1'b0;
        i_vsync = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge CLK);
            if (o_frame_start) found = 1'b1;
        end
        pushed += 8;
        cycles(3);
        i_vsync = 1'b0;
        n_checks++;
        if (found !== 1'b1) begin
            n_fail++; $display("FAIL prio_fs_timeout: got %0b want 1", found);
        end
        cycles(50);
        n_checks++;
        if (log_addr.size() - s !== 9) begin
            n_fail++; $display("FAIL prio_count: got %0d want 9", log_addr.size() - s);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (log_rw[s+i] !== 1'b0 || log_addr[s+i] !== 24'h400000 + 24'(i)) begin
                n_fail++;
                $display("FAIL prio_write%0d: got rw=%0b addr=%h want rw=0 addr=%h",
                         i, log_rw[s+i], log_addr[s+i], 24'h400000 + 24'(i));
            end
        end
        n_checks++;
        if (log_rw[s+8] !== 1'b1 || log_addr[s+8] !== 24'h000000 || fs_cnt - f !== 1) begin
            n_fail++;
            $display("FAIL prio_read_last: got rw=%0b addr=%h fs=%0d want 1 000000 1",
                     log_rw[s+8], log_addr[s+8], fs_cnt - f);
        end
    endtask

    task automatic test_underrun();
        int s, f;
        logic found, found2;
        s = log_addr.size(); f = fs_cnt; found = 1'b0; found2 = 1'b0;
        i_vsync = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge CLK);
            if (o_frame_start) found = 1'b1;
        end
        pushed += 8;
        cycles(2);
        i_vsync = 1'b0;
        for (int k = 0; k < 60 && !found2; k++) begin
            cycles(1);
            if (o_enable && !o_rw && o_addr == 24'h000007) found2 = 1'b1;
        end
        i_sdram_busy = 1'b1;
        n_checks++;
        if (found !== 1'b1 || found2 !== 1'b1) begin
            n_fail++; $display("FAIL underrun_setup_timeout: got %0b%0b want 11", found, found2);
        end
        i_vsync = 1'b1;
        cycles(8);
        n_checks++;
        if (o_enable !== 1'b1 || o_addr !== 24'h000007) begin
            n_fail++; $display("FAIL underrun_hold: got en=%0b addr=%h want 1 000007", o_enable, o_addr);
        end
        i_vsync = 1'b0;
        i_sdram_busy = 1'b0;
        cycles(25);
        n_checks++;
        if (o_error !== 2'b11) begin
            n_fail++; $display("FAIL underrun_error: got %b want 11", o_error);
        end
        n_checks++;
        if (fs_cnt - f !== 2 || log_addr.size() - s !== 9) begin
            n_fail++;
            $display("FAIL underrun_counts: got fs=%0d n=%0d want 2 9", fs_cnt - f, log_addr.size() - s);
        end
        n_checks++;
        if (log_rw[s+7] !== 1'b0 || log_addr[s+7] !== 24'h000007 ||
            log_rw[s+8] !== 1'b1 || log_addr[s+8] !== 24'h000000) begin
            n_fail++;
            $display("FAIL underrun_cmds: got %0b/%h %0b/%h want 0/000007 1/000000",
                     log_rw[s+7], log_addr[s+7], log_rw[s+8], log_addr[s+8]);
        end
    endtask

    task automatic test_reset_mid();
        int s, r;
        i_sdram_busy = 1'b1;
        pushed += 1;
        for (int k = 0; k < 20 && !o_enable; k++) cycles(1);
        n_checks++;
        if (o_enable !== 1'b1 || o_addr !== 24'h400000) begin
            n_fail++; $display("FAIL rst_setup: got en=%0b addr=%h want 1 400000", o_enable, o_addr);
        end
        #2;
        RST = 1'b0;
        #1;
        n_checks++;
        if ({o_enable, o_rw, o_addr, o_fifo_rd_en, o_frame_start, o_error} !== 29'd0) begin
            n_fail++;
            $display("FAIL async_reset: got en=%0b rw=%0b addr=%h rd=%0b fs=%0b err=%b want all zero",
                     o_enable, o_rw, o_addr, o_fifo_rd_en, o_frame_start, o_error);
        end
        cycles(2);
        RST = 1'b1;
        i_sdram_busy = 1'b0;
        s = log_addr.size(); r = rd_en_cnt;
        cycles(20);
        n_checks++;
        if (log_addr.size() - s !== 0 || rd_en_cnt - r !== 0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got cmds=%0d rd_en=%0d want 0 0", log_addr.size() - s, rd_en_cnt - r);
        end
        pulse_vsync();
        cycles(20);
        n_checks++;
        if (log_addr.size() - s !== 1 || log_rw[s] !== 1'b0 || log_addr[s] !== 24'h000000) begin
            n_fail++;
            $display("FAIL post_reset_write: got n=%0d rw=%0b addr=%h want 1 0 000000",
                     log_addr.size() - s, log_rw[s], log_addr[s]);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_swap_read();
        test_discard();
        test_overrun();
        test_busy_hold();
        test_write_priority();
        test_underrun();
        test_reset_mid();
        n_checks++;
        if (empty_pop_cnt !== 0) begin
            n_fail++; $display("FAIL pop_while_empty: got %0d want 0", empty_pop_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_frame_sequencer.md
# sdram_frame_sequencer

Control stage between the pixel clock-crossing FIFO and the SDRAM controller in the VGA capture path. Drains captured pixels from the FIFO into one SDRAM frame buffer while reading the previously completed frame back out of the other in bursts for the compressor/UART path. Ping-pongs the two buffers on each VSYNC. Provides the enable, read/write and address logic for the SDRAM controller in the VGA top level.

## Interface
- FrameWidth, 640, pixels per line
- FrameHeight, 480, lines per frame
- AddressWidth, 24, SDRAM linear address width: bank(2) + row(13) + col(9)
- BurstLen, 8, words returned per SDRAM read command; FrameWidth*FrameHeight must be a multiple of it
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-low
- i_vsync  in  1  VSYNC from the p_clk domain, async to CLK; internally synchronised with 2 flops
- i_fifo_empty  in  1  FIFO empty; FIFO is first-word-fall-through
- o_fifo_rd_en  out  1  pop one FIFO word
- i_sdram_busy  in  1  SDRAM controller busy; a command is accepted when o_enable=1 and i_sdram_busy=0
- o_enable  out  1  command request to SDRAM
- o_rw  out  1  0 = write, 1 = read
- o_addr  out  AddressWidth  linear word address
- o_frame_start  out  1  one-cycle pulse when a readout frame begins
- o_error  out  2  sticky: [0] write overrun (VSYNC before write frame complete), [1] read underrun (VSYNC before readout complete)

## Operation
- Buffer select bit `wbuf`: write buffer = bank wbuf, read buffer = bank ~wbuf. Address = {bank[1:0], pixel index zero-extended to 22 bits}, bank = {1'b0, buf}.
- Counters: wr_idx and rd_idx, each 0..N where N = FrameWidth*FrameHeight. `rd_active` is the readout-in-progress flag.
- States: SYNC, ARB, WR_CMD, RD_CMD, WAIT.
- SYNC (after reset): wait for the first VSYNC rising edge. Then set wr_idx=0 and wbuf=0, go to ARB. No reads occur until the first frame is written.
- ARB, in priority order:
  - VSYNC edge: swap event.
  - FIFO non-empty and wr_idx<N: go to WR_CMD.
  - FIFO non-empty and wr_idx==N: discard the word (o_fifo_rd_en=1 for one cycle, no SDRAM command), stay in ARB.
  - rd_active and rd_idx<N: go to RD_CMD.
  - Otherwise stay in ARB.
- WR_CMD: o_enable=1, o_rw=0, o_addr={0,wbuf,wr_idx}. On acceptance: o_fifo_rd_en=1 in the same cycle, wr_idx+=1, go to WAIT.
- RD_CMD: o_enable=1, o_rw=1, o_addr={0,~wbuf,rd_idx}. On acceptance: rd_idx+=BurstLen, go to WAIT. When rd_idx reaches N, clear rd_active.
- WAIT: hold o_enable=0 for one cycle while the controller raises busy, then go to ARB.
- Swap event (VSYNC edge seen in ARB, or latched while in any other state and serviced at the next ARB):
  - If wr_idx<N: set o_error[0]. Restart the same buffer with wr_idx=0. No swap, no readout.
  - Else:
    - If rd_active: set o_error[1].
    - Toggle wbuf, wr_idx=0, rd_idx=0, rd_active=1, pulse o_frame_start.
- o_addr, o_rw and o_enable stay stable while o_enable=1 until acceptance. A command is never withdrawn.
- Writes have strict priority over reads, so FIFO overflow is avoided at the expense of read latency.

## Timing
- Reset values: o_enable=0, o_rw=0, o_addr=0, o_fifo_rd_en=0, o_frame_start=0, o_error=0. State=SYNC, wbuf=0, rd_active=0.
- RST asserted mid-command drops o_enable asynchronously. The SDRAM controller shares RST.
- VSYNC latency: rising edge at the synchroniser input is recognised as an edge 3 CLK later. A swap happens in that cycle if state=ARB, otherwise at the next ARB cycle. At most one pending swap is latched.
- Write throughput: at most 1 word per 3 CLK (ARB, WR_CMD, WAIT) with busy=0. Each additional busy cycle adds 1 CLK.
- o_fifo_rd_en is never asserted while i_fifo_empty=1.
- o_frame_start rises in the cycle after the swap decision, for exactly 1 CLK.
- Counter arithmetic is unsigned. Indices never exceed N. No wrap within a frame.

## Test plan
- Parameters FrameWidth=4, FrameHeight=2 (N=8), BurstLen=8, busy=0, FIFO preloaded with 8 words, then VSYNC → exactly 8 writes, addresses 0x000000..0x000007, o_rw=0, 8 rd_en pulses, no reads. Then a second VSYNC → o_frame_start pulse and one read at 0x000000 (bank 0) with o_rw=1. Subsequent writes go to 0x400000+.
- FIFO holds 10 words after a full frame → 8 writes, 2 discard pops with o_enable=0, o_error=0.
- VSYNC after only 5 writes → o_error=2'b01, next write at 0x000000 (same bank), no o_frame_start.
- Hold i_sdram_busy=1 for 5 cycles while WR_CMD is pending → o_enable and o_addr held stable. Acceptance and rd_en happen on the first busy=0 cycle.
- FIFO continuously non-empty while readout is pending → every command is a write until the frame completes. Then the read is issued. A VSYNC arriving with rd_active still set → o_error[1]=1.
- Assert RST during WR_CMD → all outputs 0 asynchronously. After release, no command is issued before the first VSYNC.
